// File: rtl/noc_axi_pkg.sv
// noc_axi_pkg: shared FSM encoding, AXI response codes and default widths for the NoC arbiters
package noc_axi_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP, ST_ERR} state_t;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int DEF_NUM_MASTERS = 4;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_WDOG_CYCLES = 256;
endpackage

// File: rtl/noc_rr_picker.sv
// noc_rr_picker: one-hot find-first-set of req starting at ptr, wrapping modulo N
module noc_rr_picker #(
    parameter int N = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    // scan from the farthest offset down so the nearest requester wins
    always_comb begin
        gnt = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[PW'((int'(ptr) + k) % N)]) begin
                gnt = '0;
                gnt[PW'((int'(ptr) + k) % N)] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/noc_axi_wr_arbiter.sv
// noc_axi_wr_arbiter: round-robin AXI-lite write arbiter, grant held from AW through B.
// NOC_ARB_WDOG_EN adds a watchdog that answers SLVERR on a stalled phase and sets sticky wdog_err.
module noc_axi_wr_arbiter
    import noc_axi_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
`ifdef NOC_ARB_WDOG_EN
    ,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
`endif
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_awaddr,
    input  logic [NUM_MASTERS-1:0]        m_awvalid,
    output logic [NUM_MASTERS-1:0]        m_awready,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0]        m_wvalid,
    output logic [NUM_MASTERS-1:0]        m_wready,
    output logic [1:0]                    m_bresp,
    output logic [NUM_MASTERS-1:0]        m_bvalid,
    input  logic [NUM_MASTERS-1:0]        m_bready,
    output logic [ADDR_W-1:0]             s_awaddr,
    output logic                          s_awvalid,
    input  logic                          s_awready,
    output logic [DATA_W-1:0]             s_wdata,
    output logic                          s_wvalid,
    input  logic                          s_wready,
    input  logic [1:0]                    s_bresp,
    input  logic                          s_bvalid,
    output logic                          s_bready,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic                          busy
`ifdef NOC_ARB_WDOG_EN
    ,
    output logic                          wdog_err
`endif
);
    localparam int PW = $clog2(NUM_MASTERS);

    state_t state, state_nxt;
    logic [NUM_MASTERS-1:0] grant_nxt, pick;
    logic [PW-1:0] rr_ptr, rr_nxt, gidx;
    logic wdog_hit;

    noc_rr_picker #(.N(NUM_MASTERS), .PW(PW)) u_pick (.req(m_awvalid), .ptr(rr_ptr), .gnt(pick));

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) if (grant[i]) gidx = PW'(i);
    end

    // pass-throughs are gated by state so idle masters never leak onto the slave port
    always_comb begin
        busy = state != ST_IDLE;
        s_awvalid = (state == ST_ADDR) && |(m_awvalid & grant);
        s_awaddr = (state == ST_ADDR) ? m_awaddr[int'(gidx)*ADDR_W +: ADDR_W] : '0;
        m_awready = (state == ST_ADDR && s_awready) ? grant : '0;
        s_wvalid = (state == ST_DATA) && |(m_wvalid & grant);
        s_wdata = (state == ST_DATA) ? m_wdata[int'(gidx)*DATA_W +: DATA_W] : '0;
        m_wready = (state == ST_DATA && s_wready) ? grant : '0;
        s_bready = (state == ST_RESP) && |(m_bready & grant);
        m_bvalid = ((state == ST_RESP && s_bvalid) || state == ST_ERR) ? grant : '0;
        m_bresp = (state == ST_RESP) ? s_bresp : (state == ST_ERR) ? RESP_SLVERR : RESP_OKAY;
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt = rr_ptr;
        case (state)
            ST_IDLE: if (|m_awvalid) begin
                state_nxt = ST_ADDR;
                grant_nxt = pick;
            end
            ST_ADDR: state_nxt = (s_awvalid && s_awready) ? ST_DATA : wdog_hit ? ST_ERR : ST_ADDR;
            ST_DATA: state_nxt = (s_wvalid && s_wready) ? ST_RESP : wdog_hit ? ST_ERR : ST_DATA;
            ST_RESP: state_nxt = (s_bvalid && s_bready) ? ST_IDLE : wdog_hit ? ST_ERR : ST_RESP;
            ST_ERR: if (|(m_bready & grant)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (state != ST_IDLE && state_nxt == ST_IDLE) begin
            grant_nxt = '0;
            rr_nxt = (int'(gidx) == NUM_MASTERS - 1) ? '0 : gidx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            grant <= '0;
            rr_ptr <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            rr_ptr <= rr_nxt;
        end
    end

`ifdef NOC_ARB_WDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES);
    logic [CW-1:0] wdog_cnt;
    assign wdog_hit = wdog_cnt == CW'(WDOG_CYCLES - 1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            wdog_cnt <= (state_nxt != state || state == ST_IDLE || state == ST_ERR) ? '0 : wdog_cnt + 1'b1;
            if (state_nxt == ST_ERR) wdog_err <= 1'b1;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    // dropping awvalid before the address is accepted breaks the serialisation contract
    a_awvalid_held: assert property (@(posedge clk) disable iff (!reset_n)
        state == ST_ADDR |-> |(m_awvalid & grant));
endmodule
